// File: rtl/vpu_vec_core_pkg.sv
// Shared encodings for the lane-sliced vector core: RVV opcode/funct fields,
// the internal ALU op set, FSM states and the instruction decoder.
package vpu_vec_core_pkg;

    localparam logic [6:0] OPC_OPV   = 7'b1010111;
    localparam logic [2:0] F3_OPIVV  = 3'b000;
    localparam logic [2:0] F3_OPIVX  = 3'b100;

    localparam logic [5:0] F6_VADD  = 6'b000000;
    localparam logic [5:0] F6_VSUB  = 6'b000010;
    localparam logic [5:0] F6_VAND  = 6'b001001;
    localparam logic [5:0] F6_VOR   = 6'b001010;
    localparam logic [5:0] F6_VXOR  = 6'b001011;
    localparam logic [5:0] F6_VMINU = 6'b000100;
    localparam logic [5:0] F6_VMAXU = 6'b000110;
    localparam logic [5:0] F6_VMV   = 6'b010111;

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MINU, OP_MAXU, OP_MV
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    typedef struct packed {
        logic    legal;
        logic    is_vx;
        alu_op_t op;
    } decode_t;

    function automatic decode_t decode_instr(input logic [31:0] word);
        decode_t d;
        d.legal = 1'b1;
        d.is_vx = (word[14:12] == F3_OPIVX);
        d.op    = OP_ADD;
        case (word[31:26])
            F6_VADD:  d.op = OP_ADD;
            F6_VSUB:  d.op = OP_SUB;
            F6_VAND:  d.op = OP_AND;
            F6_VOR:   d.op = OP_OR;
            F6_VXOR:  d.op = OP_XOR;
            F6_VMINU: d.op = OP_MINU;
            F6_VMAXU: d.op = OP_MAXU;
            F6_VMV:   d.op = OP_MV;
            default:  d.legal = 1'b0;
        endcase
        if (word[6:0] != OPC_OPV) d.legal = 1'b0;
        if (word[14:12] != F3_OPIVV && word[14:12] != F3_OPIVX) d.legal = 1'b0;
        // vm (bit 25) is deliberately ignored: there is no masking.
        return d;
    endfunction

endpackage

// File: rtl/vpu_vec_core_lane_alu.sv
// One element-wide ALU lane; a is operand 1 (vs1 or scalar), b is vs2.
module vpu_lane_alu
    import vpu_vec_core_pkg::*;
#(
    parameter int ELEN = 32
) (
    input  alu_op_t         op,
    input  logic [ELEN-1:0] a,
    input  logic [ELEN-1:0] b,
    output logic [ELEN-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = b + a;
            OP_SUB:  y = b - a;
            OP_AND:  y = b & a;
            OP_OR:   y = b | a;
            OP_XOR:  y = b ^ a;
            OP_MINU: y = (a < b) ? a : b;
            OP_MAXU: y = (a > b) ? a : b;
            OP_MV:   y = a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/vpu_vec_core.sv
// Multi-beat vector core: accepts one OPIVV/OPIVX instruction at a time,
// computes LANES elements per beat and writes the whole vd in a WB cycle.
module vpu_vec_core
    import vpu_vec_core_pkg::*;
#(
    parameter int VLEN      = 128,
    parameter int ELEN      = 32,
    parameter int LANES     = 2,
    parameter int NUM_VREGS = 32,
    localparam int RIDX_W   = $clog2(NUM_VREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    input  logic [ELEN-1:0]   instr_scalar,
    output logic              wb_valid,
    output logic [RIDX_W-1:0] wb_vd,
    output logic              illegal,
    output logic [31:0]       retired_cnt,
    input  logic [RIDX_W-1:0] dbg_idx,
    output logic [VLEN-1:0]   dbg_data
);

    localparam int SLICE  = ELEN * LANES;
    localparam int BEATS  = VLEN / SLICE;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_t            state_reg, state_next;
    logic [BEAT_W-1:0] beat_reg;
    alu_op_t           op_reg;
    logic              is_vx_reg;
    logic [RIDX_W-1:0] vd_reg;
    logic [ELEN-1:0]   scalar_reg;
    logic [VLEN-1:0]   vs1_data_reg, vs2_data_reg, result_reg;
    logic [31:0]       retired_cnt_reg;
    logic              illegal_reg;
    logic [VLEN-1:0]   vregs [NUM_VREGS];

    decode_t           dec;
    logic              accept;
    logic [RIDX_W-1:0] vd_idx, vs1_idx, vs2_idx;
    logic [SLICE-1:0]  lane_y;

    assign dec     = decode_instr(instr);
    assign vd_idx  = instr[7 +: RIDX_W];
    assign vs1_idx = instr[15 +: RIDX_W];
    assign vs2_idx = instr[20 +: RIDX_W];
    assign accept  = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept && dec.legal) state_next = ST_EXEC;
            ST_EXEC: if (beat_reg == LAST_BEAT) state_next = ST_WB;
            ST_WB:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state_reg == ST_IDLE);
        wb_valid    = (state_reg == ST_WB);
        wb_vd       = (state_reg == ST_WB) ? vd_reg : '0;
    end

    // Each lane picks its element of the current beat from the latched operands.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [ELEN-1:0] lane_a, lane_b;
            assign lane_a = is_vx_reg ? scalar_reg
                          : vs1_data_reg[(int'(beat_reg) * LANES + gi) * ELEN +: ELEN];
            assign lane_b = vs2_data_reg[(int'(beat_reg) * LANES + gi) * ELEN +: ELEN];
            vpu_lane_alu #(.ELEN(ELEN)) u_alu (
                .op (op_reg),
                .a  (lane_a),
                .b  (lane_b),
                .y  (lane_y[gi * ELEN +: ELEN])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_reg        <= '0;
            op_reg          <= OP_ADD;
            is_vx_reg       <= 1'b0;
            vd_reg          <= '0;
            scalar_reg      <= '0;
            vs1_data_reg    <= '0;
            vs2_data_reg    <= '0;
            result_reg      <= '0;
            retired_cnt_reg <= '0;
            illegal_reg     <= 1'b0;
        end else begin
            illegal_reg <= accept && !dec.legal;
            case (state_reg)
                ST_IDLE: begin
                    // Operands are captured here, so vd aliasing a source is harmless.
                    if (accept && dec.legal) begin
                        vs1_data_reg <= vregs[vs1_idx];
                        vs2_data_reg <= vregs[vs2_idx];
                        scalar_reg   <= instr_scalar;
                        op_reg       <= dec.op;
                        is_vx_reg    <= dec.is_vx;
                        vd_reg       <= vd_idx;
                        beat_reg     <= '0;
                    end
                end
                ST_EXEC: begin
                    result_reg[int'(beat_reg) * SLICE +: SLICE] <= lane_y;
                    beat_reg <= beat_reg + 1'b1;
                end
                ST_WB: retired_cnt_reg <= retired_cnt_reg + 32'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VREGS; i++) vregs[i] <= '0;
        end else if (state_reg == ST_WB) begin
            vregs[vd_reg] <= result_reg;
        end
    end

    assign illegal     = illegal_reg;
    assign retired_cnt = retired_cnt_reg;
    assign dbg_data    = vregs[dbg_idx];

endmodule

// File: tb/tb_vpu_vec_core.sv
// Self-checking bench for vpu_vec_core: directed corner cases plus randomized
// instructions compared against an element-level reference model.
module tb_vpu_vec_core;

    localparam int VLEN      = 128;
    localparam int ELEN      = 32;
    localparam int LANES     = 2;
    localparam int NUM_VREGS = 32;
    localparam int RIDX_W    = 5;
    localparam int BEATS     = VLEN / (ELEN * LANES);
    localparam int NELEM     = VLEN / ELEN;

    logic              clk = 1'b0;
    logic              rst;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [ELEN-1:0]   instr_scalar;
    logic              wb_valid;
    logic [RIDX_W-1:0] wb_vd;
    logic              illegal;
    logic [31:0]       retired_cnt;
    logic [RIDX_W-1:0] dbg_idx;
    logic [VLEN-1:0]   dbg_data;

    always #5 clk = ~clk;

    vpu_vec_core #(
        .VLEN(VLEN), .ELEN(ELEN), .LANES(LANES), .NUM_VREGS(NUM_VREGS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .instr_scalar (instr_scalar),
        .wb_valid     (wb_valid),
        .wb_vd        (wb_vd),
        .illegal      (illegal),
        .retired_cnt  (retired_cnt),
        .dbg_idx      (dbg_idx),
        .dbg_data     (dbg_data)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [VLEN-1:0] mreg [NUM_VREGS];
    logic [31:0]     mretired;

    task automatic check(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [5:0] f6, input logic [2:0] f3,
                                        input int vd, input int vs2, input int vs1);
        return {f6, 1'b1, 5'(vs2), 5'(vs1), f3, 5'(vd), 7'b1010111};
    endfunction

    function automatic logic [VLEN-1:0] rep(input logic [ELEN-1:0] e);
        return {NELEM{e}};
    endfunction

    function automatic bit ref_legal(input logic [31:0] w);
        logic [5:0] f6;
        f6 = w[31:26];
        if (w[6:0] != 7'b1010111) return 1'b0;
        if (w[14:12] != 3'b000 && w[14:12] != 3'b100) return 1'b0;
        return f6 inside {6'h00, 6'h02, 6'h09, 6'h0A, 6'h0B, 6'h04, 6'h06, 6'h17};
    endfunction

    // Element-by-element result: op1 is vs1 element or scalar, op2 is vs2 element.
    function automatic logic [VLEN-1:0] ref_result(input logic [31:0] w, input logic [ELEN-1:0] s);
        logic [VLEN-1:0] v1, v2, r;
        logic [ELEN-1:0] a, b, y;
        v1 = mreg[int'(w[19:15]) % NUM_VREGS];
        v2 = mreg[int'(w[24:20]) % NUM_VREGS];
        r  = '0;
        for (int e = 0; e < NELEM; e++) begin
            a = (w[14:12] == 3'b100) ? s : v1[e*ELEN +: ELEN];
            b = v2[e*ELEN +: ELEN];
            case (w[31:26])
                6'h00:   y = b + a;
                6'h02:   y = b - a;
                6'h09:   y = b & a;
                6'h0A:   y = b | a;
                6'h0B:   y = b ^ a;
                6'h04:   y = (a < b) ? a : b;
                6'h06:   y = (a > b) ? a : b;
                default: y = a;
            endcase
            r[e*ELEN +: ELEN] = y;
        end
        return r;
    endfunction

    task automatic wait_ready(input string tag);
        for (int k = 0; k < 20 && !instr_ready; k++) @(negedge clk);
        if (!instr_ready) check({tag, "_ready_timeout"}, instr_ready, 1);
    endtask

    // Present a word from a negedge; returns at the negedge after the accept edge.
    task automatic send(input string tag, input logic [31:0] w, input logic [ELEN-1:0] s,
                        input bit hold, output int acc);
        @(negedge clk);
        instr = w; instr_scalar = s; instr_valid = 1'b1;
        wait_ready(tag);
        @(posedge clk);
        #1 acc = cyc;
        @(negedge clk);
        if (!hold) instr_valid = 1'b0;
    endtask

    task automatic run(input string tag, input logic [31:0] w, input logic [ELEN-1:0] s);
        bit legal, seen;
        logic [VLEN-1:0] exp_res;
        int vd, acc;
        legal   = ref_legal(w);
        exp_res = ref_result(w, s);
        vd      = int'(w[11:7]) % NUM_VREGS;
        send(tag, w, s, 1'b0, acc);
        if (!legal) begin
            check({tag, "_illegal_pulse"}, illegal, 1);
            check({tag, "_illegal_ready"}, instr_ready, 1);
            @(negedge clk);
            check({tag, "_illegal_once"}, illegal, 0);
            check({tag, "_illegal_nowb"}, wb_valid, 0);
            check({tag, "_illegal_retired"}, retired_cnt, mretired);
            return;
        end
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (wb_valid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        if (!seen) begin
            check({tag, "_wb_timeout"}, wb_valid, 1);
            return;
        end
        check({tag, "_latency"}, cyc + 1 - acc, BEATS + 1);
        check({tag, "_wb_vd"}, wb_vd, vd);
        dbg_idx = RIDX_W'(vd);
        #1 check({tag, "_dbg_old"}, dbg_data, mreg[vd]);
        @(negedge clk);
        mreg[vd] = exp_res;
        mretired = mretired + 32'd1;
        #1;
        check({tag, "_result"}, dbg_data, exp_res);
        check({tag, "_wb_pulse"}, wb_valid, 0);
        check({tag, "_ready"}, instr_ready, 1);
        check({tag, "_retired"}, retired_cnt, mretired);
    endtask

    task automatic dbg_check(input string tag, input int idx, input logic [VLEN-1:0] exp);
        dbg_idx = RIDX_W'(idx);
        #1 check(tag, dbg_data, exp);
    endtask

    localparam logic [5:0] F6_LIST [8] = '{6'h00, 6'h02, 6'h09, 6'h0A, 6'h0B, 6'h04, 6'h06, 6'h17};

    initial begin
        int a1, a2, wb_hits;
        logic [31:0] w;
        logic [5:0]  f6;
        logic [2:0]  f3;

        for (int i = 0; i < NUM_VREGS; i++) mreg[i] = '0;
        mretired     = '0;
        rst          = 1'b1;
        instr_valid  = 1'b0;
        instr        = '0;
        instr_scalar = '0;
        dbg_idx      = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("reset_ready", instr_ready, 1);
        check("reset_wb_valid", wb_valid, 0);
        check("reset_wb_vd", wb_vd, 0);
        check("reset_illegal", illegal, 0);
        check("reset_retired", retired_cnt, 0);
        dbg_check("reset_v5", 5, '0);

        run("vmv_v1", enc(6'h17, 3'b100, 1, 0, 0), 32'd5);
        dbg_check("vmv_v1_const", 1, rep(32'd5));
        run("vmv_v2", enc(6'h17, 3'b100, 2, 0, 0), 32'd7);
        run("vsub_v3", enc(6'h02, 3'b000, 3, 2, 1), '0);
        dbg_check("vsub_v3_const", 3, rep(32'd2));
        run("vsub_v4", enc(6'h02, 3'b000, 4, 1, 2), '0);
        dbg_check("vsub_v4_const", 4, rep(32'hFFFF_FFFE));

        // Back-to-back RAW on v5 with valid held across both accepts.
        send("b2b_1", enc(6'h00, 3'b000, 5, 1, 1), '0, 1'b1, a1);
        mreg[5] = ref_result(enc(6'h00, 3'b000, 5, 1, 1), '0);
        send("b2b_2", enc(6'h00, 3'b000, 5, 5, 5), '0, 1'b0, a2);
        mreg[5] = ref_result(enc(6'h00, 3'b000, 5, 5, 5), '0);
        mretired = mretired + 32'd2;
        check("b2b_gap", a2 - a1, BEATS + 2);
        @(negedge clk);
        wait_ready("b2b_done");
        dbg_check("b2b_v5", 5, rep(32'd20));
        check("b2b_retired", retired_cnt, mretired);

        run("illegal_f6", {6'b110000, 1'b1, 5'd1, 5'd1, 3'b000, 5'd1, 7'b1010111}, '0);
        dbg_check("illegal_v1_kept", 1, rep(32'd5));

        run("vmv_v7", enc(6'h17, 3'b100, 7, 0, 0), 32'h8000_0000);
        run("vmaxu_v8", enc(6'h06, 3'b100, 8, 7, 0), 32'd1);
        dbg_check("vmaxu_const", 8, rep(32'h8000_0000));
        run("vminu_v9", enc(6'h04, 3'b100, 9, 7, 0), 32'd1);
        dbg_check("vminu_const", 9, rep(32'd1));

        for (int i = 0; i < 80; i++) begin
            f6 = ($urandom_range(0, 9) == 0) ? 6'($urandom) : F6_LIST[$urandom_range(0, 7)];
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : ($urandom_range(0, 1) ? 3'b100 : 3'b000);
            w  = enc(f6, f3, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) w[6:0] = 7'($urandom);
            run($sformatf("rnd%0d", i), w, $urandom);
        end
        for (int i = 0; i < NUM_VREGS; i++) dbg_check($sformatf("sweep_v%0d", i), i, mreg[i]);

        // Reset during the first EXEC cycle must drop the instruction.
        send("rst_mid", enc(6'h17, 3'b100, 6, 0, 0), 32'h1234, 1'b0, a1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NUM_VREGS; i++) mreg[i] = '0;
        mretired = '0;
        wb_hits = 0;
        for (int k = 0; k < 5; k++) begin
            if (wb_valid) wb_hits++;
            @(negedge clk);
        end
        check("rst_mid_no_wb", wb_hits, 0);
        check("rst_mid_ready", instr_ready, 1);
        check("rst_mid_retired", retired_cnt, 0);
        dbg_check("rst_mid_v6", 6, '0);
        dbg_check("rst_mid_v1", 1, '0);

        force dut.retired_cnt_reg = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.retired_cnt_reg;
        #1 check("wrap_preset", retired_cnt, 32'hFFFF_FFFF);
        mretired = 32'hFFFF_FFFF;
        run("wrap_vmv", enc(6'h17, 3'b100, 10, 0, 0), 32'd3);
        check("wrap_zero", retired_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
